sevenseg_capture: RTL and testbench
===================================

Name: sevenseg_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Watches the driver's digit-enable and segment lines and rebuilds the four displayed BCD digits (MM:SS).
- Debounces each digit over repeated scans and flags bad activity: multiple enables, non-decimal patterns, loss of scanning.
- Used for on-board self-check and for feeding the displayed time back to the clock core or bench.

Parameters:
- SEG_LAG, 1, cycles by which the segment lines lag the digit enables (valid 0..3). Enables are delayed by this amount before pairing.
- STABLE_SCANS, 2, consecutive identical decodes of a digit required before its output updates (valid 1..15).
- TIMEOUT, 1024, cycles with no valid sample before timeout asserts (valid 2..65535).

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- Digit4  in  1  enable for min2nd position, active-high
- Digit3  in  1  enable for min1st position
- Digit2  in  1  enable for sec2nd position
- Digit1  in  1  enable for sec1st position
- LedA..LedG  in  1 each  segment lines, active-high. Pattern order is {A,B,C,D,E,F,G}.
- min2nd  out  4  captured minutes 2nd digit
- min1st  out  4  captured minutes 1st digit
- sec2nd  out  4  captured seconds 2nd digit
- sec1st  out  4  captured seconds 1st digit
- valid  out  1  all four digits captured stable and no timeout
- update  out  1  one-cycle pulse when any captured digit changes
- err_multi  out  1  one-cycle pulse when more than one delayed enable is high
- err_seg  out  1  one-cycle pulse when a single enable is paired with a non-decimal pattern
- timeout  out  1  level; scanning lost

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - Enable delay line, input registers, candidates, counters, seen flags and timeout counter are cleared.
  - Reset mid-scan discards partial counts.
- Input stage:
  - Enable vector {Digit4..Digit1} and segments are registered at edge n.
  - The enable vector passes through SEG_LAG further register stages (reset 0) before pairing with the registered segments.
- Sample classification each cycle, using the delayed enable vector E:
  - E==0: idle. No action except the timeout count.
  - popcount(E)>1: err_multi=1 next cycle. No digit is touched. Counts as idle for timeout.
  - One-hot E with a decimal pattern: decode to 0..9 and route to the digit filter for that position.
    - Patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011.
  - One-hot E with any other pattern: err_seg=1 next cycle, and that digit's count is cleared to 0.
- Digit filter (one per position; state is cand[3:0], cnt[3:0], seen):
  - Good sample v with v==cand: cnt increments, saturating at STABLE_SCANS.
  - Good sample v with v!=cand: cand<=v, cnt<=1.
  - When cnt reaches STABLE_SCANS on this sample:
    - seen<=1.
    - If cand differs from the current output, the output is loaded and the digit raises its change strobe.
  - Latency: a good sample registered at edge n reaches the output at edge n+1.
- update is the OR of the four change strobes, registered. Simultaneous changes produce a single pulse.
- valid = seen[3:0]==4'b1111 and timeout==0, registered.
- Timeout:
  - The counter increments on every cycle without a good one-hot sample and saturates at TIMEOUT.
  - Any good sample clears it.
  - On reaching TIMEOUT: timeout<=1, all seen flags cleared, valid drops. Digit outputs hold their last values.
  - timeout clears on the next good sample. valid returns only after all four digits re-stabilise.
- Simultaneous err_seg and timeout in the same cycle are both reported.
- Counters do not wrap.

Decomposition:
- Package sevenseg_pkg:
  - 7-bit segment constants SEG_0..SEG_9 ({A..G} order).
  - Digit index constants POS_MIN2=3, POS_MIN1=2, POS_SEC2=1, POS_SEC1=0.
  - Decode function: pattern -> {ok, value[3:0]}.
- Sub-module sevenseg_digit_filter, instantiated four times. Holds cand, cnt, seen and the output register; parameter STABLE_SCANS.

Test Plan:
- Drive display-driver-style scanning of 1,2:5,9 (one digit per cycle, segments lagging 1). -> After 2 full scans: min2nd=1, min1st=2, sec2nd=5, sec1st=9, valid=1, update pulsed; no error pulses.
- From 12:59, change sec1st to 0 for one scan, then back to 9. -> No change, no update. Hold 0 for two scans -> sec1st=0, exactly one update pulse.
- Present delayed enables 4'b0011 with pattern 1111110. -> err_multi single pulse; outputs and counts unchanged.
- Digit1 enabled with pattern 1000000. -> err_seg pulse; sec1st holds; that digit needs STABLE_SCANS fresh good samples before it can update.
- TIMEOUT=16, enables held 0 for 16 cycles. -> timeout=1, valid=0, digits hold. Resume scanning 12:59 -> timeout=0 on first good sample; valid=1 after 2 scans.
- Assert reset low mid-scan, asynchronous to clock. -> All outputs 0 immediately. After release, one idle cycle, then normal recapture.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and pattern decoder for the seven-segment capture.
// Segment patterns are in {A,B,C,D,E,F,G} order, active-high.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110010;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam int POS_MIN2 = 3;
  localparam int POS_MIN1 = 2;
  localparam int POS_SEC2 = 1;
  localparam int POS_SEC1 = 0;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } dec_t;

  function automatic dec_t seg_decode(
    input logic [6:0] p
  );
    dec_t d;
    d = '{ok: 1'b1, val: 4'd0};
    case (p)
      SEG_0:   d.val = 4'd0;
      SEG_1:   d.val = 4'd1;
      SEG_2:   d.val = 4'd2;
      SEG_3:   d.val = 4'd3;
      SEG_4:   d.val = 4'd4;
      SEG_5:   d.val = 4'd5;
      SEG_6:   d.val = 4'd6;
      SEG_7:   d.val = 4'd7;
      SEG_8:   d.val = 4'd8;
      SEG_9:   d.val = 4'd9;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sevenseg_digit_filter.sv
// Per-position debounce: needs STABLE_SCANS identical decodes to load.
// Ports: good/bad sample strobes, value, clr; digit, seen, change.
module sevenseg_digit_filter
  import sevenseg_pkg::*;
#(
  parameter int STABLE_SCANS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       good,
  input  logic       bad,
  input  logic       clr,
  input  logic [3:0] value,
  output logic [3:0] digit,
  output logic       seen,
  output logic       change
);

  localparam logic [3:0] LIM = 4'(STABLE_SCANS);

  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic       hit;

  always_comb begin
    cand_n = cand;
    cnt_n  = cnt;
    hit    = 1'b0;
    change = 1'b0;
    if (good) begin
      if (value == cand) begin
        cnt_n = (cnt == LIM) ? LIM : cnt + 4'd1;
      end else begin
        cand_n = value;
        cnt_n  = 4'd1;
      end
      hit    = (cnt_n == LIM);
      change = hit && (cand_n != digit);
    end else if (bad) begin
      cnt_n = 4'd0;
    end else if (clr) begin
      // lost scanning breaks the run of identical decodes
      cnt_n = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand  <= 4'd0;
      cnt   <= 4'd0;
      seen  <= 1'b0;
      digit <= 4'd0;
    end else begin
      cand <= cand_n;
      cnt  <= cnt_n;
      if (hit)
        seen <= 1'b1;
      else if (clr)
        seen <= 1'b0;
      if (change)
        digit <= cand_n;
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Rebuilds the four BCD digits shown by a multiplexed 7-seg driver.
// Ports: Digit4..1 enables, LedA..G segments; digits, valid, pulses.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int SEG_LAG      = 1,
  parameter int STABLE_SCANS = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Digit4,
  input  logic       Digit3,
  input  logic       Digit2,
  input  logic       Digit1,
  input  logic       LedA,
  input  logic       LedB,
  input  logic       LedC,
  input  logic       LedD,
  input  logic       LedE,
  input  logic       LedF,
  input  logic       LedG,
  output logic [3:0] min2nd,
  output logic [3:0] min1st,
  output logic [3:0] sec2nd,
  output logic [3:0] sec1st,
  output logic       valid,
  output logic       update,
  output logic       err_multi,
  output logic       err_seg,
  output logic       timeout
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  // stage 0 is the input register; SEG_LAG more follow
  logic [3:0] en_pipe [0:SEG_LAG];
  logic [6:0] seg_r;
  logic [3:0] en;
  dec_t       dec;
  logic       onehot, multi, good, bad;
  logic [15:0] tcnt, tcnt_n;
  logic       tmo_hit;
  logic [3:0] dig [4];
  logic [3:0] seen;
  logic [3:0] chg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= SEG_LAG; k++)
        en_pipe[k] <= 4'd0;
      seg_r <= 7'd0;
    end else begin
      en_pipe[0] <= {Digit4, Digit3, Digit2, Digit1};
      for (int k = 1; k <= SEG_LAG; k++)
        en_pipe[k] <= en_pipe[k-1];
      seg_r <= {LedA, LedB, LedC, LedD, LedE, LedF, LedG};
    end
  end

  assign en     = en_pipe[SEG_LAG];
  assign dec    = seg_decode(seg_r);
  assign onehot = (en != 4'd0) && ((en & (en - 4'd1)) == 4'd0);
  assign multi  = (en != 4'd0) && !onehot;
  assign good   = onehot && dec.ok;
  assign bad    = onehot && !dec.ok;

  always_comb begin
    tcnt_n = tcnt;
    if (good)
      tcnt_n = 16'd0;
    else if (tcnt != TMO)
      tcnt_n = tcnt + 16'd1;
  end

  assign tmo_hit = !good && (tcnt_n == TMO);

  for (genvar i = 0; i < 4; i++) begin : g_pos
    sevenseg_digit_filter #(
      .STABLE_SCANS(STABLE_SCANS)
    ) u_flt (
      .clock  (clock),
      .reset  (reset),
      .good   (good && en[i]),
      .bad    (bad && en[i]),
      .clr    (tmo_hit),
      .value  (dec.val),
      .digit  (dig[i]),
      .seen   (seen[i]),
      .change (chg[i])
    );
  end

  assign min2nd = dig[POS_MIN2];
  assign min1st = dig[POS_MIN1];
  assign sec2nd = dig[POS_SEC2];
  assign sec1st = dig[POS_SEC1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt      <= 16'd0;
      timeout   <= 1'b0;
      valid     <= 1'b0;
      update    <= 1'b0;
      err_multi <= 1'b0;
      err_seg   <= 1'b0;
    end else begin
      tcnt      <= tcnt_n;
      err_multi <= multi;
      err_seg   <= bad;
      update    <= |chg;
      if (good)
        timeout <= 1'b0;
      else if (tmo_hit)
        timeout <= 1'b1;
      valid <= (&seen) && !timeout;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: scans, glitches, errors,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_sevenseg_capture;

  logic       clock = 1'b0;
  logic       reset;
  logic       Digit4, Digit3, Digit2, Digit1;
  logic       LedA, LedB, LedC, LedD, LedE, LedF, LedG;
  logic [3:0] min2nd, min1st, sec2nd, sec1st;
  logic       valid, update, err_multi, err_seg, timeout;

  int checks = 0;
  int failures = 0;
  int n_upd = 0;
  int n_multi = 0;
  int n_seg = 0;
  int u0, m0, s0;
  logic [6:0] prev_pat;

  always #5 clock = ~clock;

  sevenseg_capture #(
    .SEG_LAG(1),
    .STABLE_SCANS(2),
    .TIMEOUT(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Digit4    (Digit4),
    .Digit3    (Digit3),
    .Digit2    (Digit2),
    .Digit1    (Digit1),
    .LedA      (LedA),
    .LedB      (LedB),
    .LedC      (LedC),
    .LedD      (LedD),
    .LedE      (LedE),
    .LedF      (LedF),
    .LedG      (LedG),
    .min2nd    (min2nd),
    .min1st    (min1st),
    .sec2nd    (sec2nd),
    .sec1st    (sec1st),
    .valid     (valid),
    .update    (update),
    .err_multi (err_multi),
    .err_seg   (err_seg),
    .timeout   (timeout)
  );

  // pulses are high for one full cycle; sample at the closing edge
  always @(posedge clock) begin
    if (update)    n_upd++;
    if (err_multi) n_multi++;
    if (err_seg)   n_seg++;
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110010;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // segments lag enables by one cycle, like the driver
  task automatic tick(input logic [3:0] en, input logic [6:0] cur);
    {Digit4, Digit3, Digit2, Digit1} = en;
    {LedA, LedB, LedC, LedD, LedE, LedF, LedG} = prev_pat;
    prev_pat = cur;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0000, 7'd0);
  endtask

  task automatic scan(input int a, input int b, input int c, input int d);
    tick(4'b1000, pat(a));
    tick(4'b0100, pat(b));
    tick(4'b0010, pat(c));
    tick(4'b0001, pat(d));
  endtask

  task automatic snap;
    u0 = n_upd;
    m0 = n_multi;
    s0 = n_seg;
  endtask

  initial begin
    reset = 1'b0;
    prev_pat = 7'd0;
    {Digit4, Digit3, Digit2, Digit1} = 4'd0;
    {LedA, LedB, LedC, LedD, LedE, LedF, LedG} = 7'd0;
    @(negedge clock);
    @(negedge clock);
    check("reset_outs",
          {min2nd, min1st, sec2nd, sec1st,
           valid, update, err_multi, err_seg, timeout}, 0);
    reset = 1'b1;
    idle(1);

    // first capture of 12:59
    snap();
    scan(1, 2, 5, 9);
    scan(1, 2, 5, 9);
    idle(4);
    check("cap_min2", min2nd, 1);
    check("cap_min1", min1st, 2);
    check("cap_sec2", sec2nd, 5);
    check("cap_sec1", sec1st, 9);
    check("cap_valid", valid, 1);
    check("cap_tmo", timeout, 0);
    check("cap_upd", n_upd - u0, 4);
    check("cap_multi", n_multi - m0, 0);
    check("cap_seg", n_seg - s0, 0);

    // single-scan glitch is filtered
    snap();
    scan(1, 2, 5, 0);
    scan(1, 2, 5, 9);
    idle(4);
    check("glitch_sec1", sec1st, 9);
    check("glitch_upd", n_upd - u0, 0);

    // two scans of 0 load it
    snap();
    scan(1, 2, 5, 0);
    scan(1, 2, 5, 0);
    idle(4);
    check("chg_sec1", sec1st, 0);
    check("chg_upd", n_upd - u0, 1);

    // two enables at once
    snap();
    tick(4'b0011, pat(0));
    idle(4);
    check("multi_pulse", n_multi - m0, 1);
    check("multi_seg", n_seg - s0, 0);
    check("multi_sec1", sec1st, 0);
    check("multi_sec2", sec2nd, 5);
    check("multi_upd", n_upd - u0, 0);

    // bad pattern clears the run of 3s
    snap();
    scan(1, 2, 5, 3);
    tick(4'b0001, 7'b1000000);
    idle(4);
    check("seg_pulse", n_seg - s0, 1);
    check("seg_multi", n_multi - m0, 0);
    check("seg_sec1", sec1st, 0);
    scan(1, 2, 5, 3);
    idle(4);
    check("seg_hold", sec1st, 0);
    check("seg_noupd", n_upd - u0, 0);
    scan(1, 2, 5, 3);
    idle(4);
    check("seg_load", sec1st, 3);
    check("seg_upd", n_upd - u0, 1);
    check("seg_valid", valid, 1);

    // scanning lost
    idle(20);
    check("tmo_set", timeout, 1);
    check("tmo_valid", valid, 0);
    check("tmo_min2", min2nd, 1);
    check("tmo_sec1", sec1st, 3);
    scan(1, 2, 5, 9);
    idle(2);
    check("tmo_clr", timeout, 0);
    check("tmo_novalid", valid, 0);
    scan(1, 2, 5, 9);
    scan(1, 2, 5, 9);
    idle(4);
    check("tmo_revalid", valid, 1);
    check("tmo_sec1_new", sec1st, 9);
    check("tmo_min1", min1st, 2);

    // asynchronous reset mid-scan
    tick(4'b1000, pat(1));
    tick(4'b0100, pat(2));
    #3;
    reset = 1'b0;
    #1;
    check("arst_now",
          {min2nd, min1st, sec2nd, sec1st,
           valid, update, err_multi, err_seg, timeout}, 0);
    @(negedge clock);
    prev_pat = 7'd0;
    idle(2);
    check("arst_hold",
          {min2nd, min1st, sec2nd, sec1st, valid}, 0);
    reset = 1'b1;
    idle(1);
    snap();
    scan(1, 2, 5, 9);
    scan(1, 2, 5, 9);
    idle(4);
    check("rec_digits",
          {min2nd, min1st, sec2nd, sec1st}, 16'h1259);
    check("rec_valid", valid, 1);
    check("rec_upd", n_upd - u0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
